// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared encodings for the unified-memory arbiter: FSM states and
//           requester identifiers.
// Revision: 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Requester identifiers, also used as the round-robin pointer value
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_e;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way combinational round-robin selector. On a tie the
//           requester that was not granted last wins. The pointer register
//           lives in the parent.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic i_req_if,
  input  logic i_req_dm,
  input  logic i_last_gnt,
  output logic o_winner,
  output logic o_valid
);

  // Pick the winner: single requester wins outright, a tie goes to the
  // requester that lost last time.
  always_comb begin
    o_valid  = i_req_if | i_req_dm;
    o_winner = REQ_IF;
    if (i_req_if && i_req_dm) begin
      o_winner = ~i_last_gnt;
    end else if (i_req_dm) begin
      o_winner = REQ_DM;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Shares one single-port memory between the instruction-fetch and
//           data-memory ports. Round-robin arbitration, one outstanding
//           transaction, read responses passed through combinationally and
//           guarded by a timeout watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH_P      = 32,
  parameter int DATA_ADDR_WIDTH_P = 32,
  parameter int TIMEOUT_P         = 16   // must be >= 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_if_req,
  input  logic [DATA_ADDR_WIDTH_P-1:0] i_if_addr,
  output logic                         o_if_gnt,
  output logic                         o_if_rvalid,
  output logic [DATA_WIDTH_P-1:0]      o_if_rdata,
  input  logic                         i_dm_req,
  input  logic                         i_dm_we,
  input  logic [DATA_ADDR_WIDTH_P-1:0] i_dm_addr,
  input  logic [DATA_WIDTH_P-1:0]      i_dm_wdata,
  output logic                         o_dm_gnt,
  output logic                         o_dm_rvalid,
  output logic [DATA_WIDTH_P-1:0]      o_dm_rdata,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [DATA_ADDR_WIDTH_P-1:0] o_mem_addr,
  output logic [DATA_WIDTH_P-1:0]      o_mem_wdata,
  input  logic                         i_mem_rvalid,
  input  logic [DATA_WIDTH_P-1:0]      i_mem_rdata,
  output logic                         o_err
);

  // Timer counts 0..TIMEOUT_P-1 inside WAIT; the timeout exit stops it
  // before it could wrap.
  localparam int                 c_TMR_W    = $clog2(TIMEOUT_P) + 1;
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_P - 1);

  state_e             state_q, state_d;
  logic               owner_q, owner_d;       // meaningful only in WAIT
  logic               last_gnt_q, last_gnt_d;
  logic [c_TMR_W-1:0] timer_q, timer_d;

  logic               w_winner;
  logic               w_win_valid;
  logic               w_rsp_valid;
  logic [DATA_WIDTH_P-1:0] w_rsp_data;

  rr_arb2 u_rr_arb2 (
    .i_req_if   (i_if_req),
    .i_req_dm   (i_dm_req),
    .i_last_gnt (last_gnt_q),
    .o_winner   (w_winner),
    .o_valid    (w_win_valid)
  );

  // Next-state and output decode. Everything is forced to zero while reset
  // is held low so no strobe escapes during an asynchronous reset.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_gnt_d  = last_gnt_q;
    timer_d     = timer_q;
    o_if_gnt    = 1'b0;
    o_dm_gnt    = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_err       = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_data  = '0;

    if (reset) begin
      case (state_q)
        IDLE: begin
          // Stale i_mem_rvalid is deliberately not looked at here.
          if (w_win_valid) begin
            o_mem_req  = 1'b1;
            last_gnt_d = w_winner;
            if (w_winner == REQ_IF) begin
              o_if_gnt   = 1'b1;
              o_mem_addr = i_if_addr;
            end else begin
              o_dm_gnt    = 1'b1;
              o_mem_we    = i_dm_we;
              o_mem_addr  = i_dm_addr;
              o_mem_wdata = i_dm_wdata;
            end
            // Writes finish in the grant cycle; reads wait for a response.
            if ((w_winner == REQ_IF) || !i_dm_we) begin
              state_d = WAIT;
              owner_d = w_winner;
              timer_d = '0;
            end
          end
        end
        WAIT: begin
          timer_d = timer_q + c_TMR_W'(1);
          if (i_mem_rvalid) begin
            w_rsp_valid = 1'b1;
            w_rsp_data  = i_mem_rdata;
            state_d     = IDLE;
          end else if (timer_q == c_TMR_LAST) begin
            w_rsp_valid = 1'b1;
            o_err       = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Steer the response to the owner only; the other port stays at zero.
  always_comb begin
    o_if_rvalid = 1'b0;
    o_if_rdata  = '0;
    o_dm_rvalid = 1'b0;
    o_dm_rdata  = '0;
    if (w_rsp_valid) begin
      if (owner_q == REQ_IF) begin
        o_if_rvalid = 1'b1;
        o_if_rdata  = w_rsp_data;
      end else begin
        o_dm_rvalid = 1'b1;
        o_dm_rdata  = w_rsp_data;
      end
    end
  end

  // State registers; last_gnt resets to DM so IF wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= REQ_IF;
      last_gnt_q <= REQ_DM;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      timer_q    <= timer_d;
    end
  end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed self-checking bench for mem_arbiter (TIMEOUT_P = 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt, o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_dm_req, i_dm_we;
  logic [31:0] i_dm_addr, i_dm_wdata;
  logic        o_dm_gnt, o_dm_rvalid;
  logic [31:0] o_dm_rdata;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH_P(32), .DATA_ADDR_WIDTH_P(32), .TIMEOUT_P(4)) dut (
    .clk(clk), .reset(reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
    .i_dm_wdata(i_dm_wdata),
    .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_err(o_err)
  );

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic inputs_idle();
    i_if_req = 0; i_if_addr = 0;
    i_dm_req = 0; i_dm_we = 0; i_dm_addr = 0; i_dm_wdata = 0;
    i_mem_rvalid = 0; i_mem_rdata = 0;
  endtask

  task automatic apply_reset();
    next_cyc(); inputs_idle(); reset = 0;
    next_cyc(); reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    i_if_req = 1; i_if_addr = 32'h4; i_dm_req = 1; i_dm_we = 1;
    i_dm_addr = 32'h8; i_dm_wdata = 32'h9; i_mem_rvalid = 1; i_mem_rdata = 32'h77;
    next_cyc(); #1;
    checks++;
    if ({o_if_gnt, o_dm_gnt, o_mem_req, o_mem_we, o_if_rvalid, o_dm_rvalid, o_err} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000000",
        {o_if_gnt, o_dm_gnt, o_mem_req, o_mem_we, o_if_rvalid, o_dm_rvalid, o_err});
    end
    checks++;
    if ({o_mem_addr, o_mem_wdata, o_if_rdata, o_dm_rdata} !== 128'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0",
        {o_mem_addr, o_mem_wdata, o_if_rdata, o_dm_rdata});
    end
    inputs_idle();
    next_cyc(); reset = 1;
  endtask

  task automatic test_if_read();
    next_cyc(); i_if_req = 1; i_if_addr = 32'h100; #1;
    checks++;
    if ({o_if_gnt, o_dm_gnt, o_mem_req, o_mem_we} !== 4'b1010 || o_mem_addr !== 32'h100) begin
      errors++; $display("FAIL if_grant: got gnt/req/we=%b addr=%h want 1010 addr=100",
        {o_if_gnt, o_dm_gnt, o_mem_req, o_mem_we}, o_mem_addr);
    end
    next_cyc(); i_if_req = 0; #1;
    checks++;
    if ({o_if_gnt, o_mem_req, o_if_rvalid} !== 3'b000) begin
      errors++; $display("FAIL if_wait1: got %b want 000", {o_if_gnt, o_mem_req, o_if_rvalid});
    end
    next_cyc();
    next_cyc(); i_mem_rvalid = 1; i_mem_rdata = 32'hDEADBEEF; #1;
    checks++;
    if (o_if_rvalid !== 1'b1 || o_if_rdata !== 32'hDEADBEEF || o_err !== 1'b0 || o_dm_rvalid !== 1'b0) begin
      errors++; $display("FAIL if_resp: got rv=%b rd=%h err=%b dmrv=%b want 1 DEADBEEF 0 0",
        o_if_rvalid, o_if_rdata, o_err, o_dm_rvalid);
    end
    next_cyc(); i_mem_rvalid = 0; i_mem_rdata = 0;
  endtask

  task automatic test_tie();
    apply_reset();
    i_if_req = 1; i_if_addr = 32'h10; i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h20; #1;
    checks++;
    if ({o_if_gnt, o_dm_gnt} !== 2'b10 || o_mem_addr !== 32'h10) begin
      errors++; $display("FAIL tie_first: got gnt=%b addr=%h want 10 addr=10",
        {o_if_gnt, o_dm_gnt}, o_mem_addr);
    end
    next_cyc(); i_if_req = 0; #1;
    checks++;
    if ({o_dm_gnt, o_mem_req} !== 2'b00) begin
      errors++; $display("FAIL tie_wait_nogrant: got %b want 00", {o_dm_gnt, o_mem_req});
    end
    next_cyc(); i_mem_rvalid = 1; i_mem_rdata = 32'h11111111; #1;
    checks++;
    if ({o_if_rvalid, o_dm_rvalid, o_dm_gnt} !== 3'b100 || o_if_rdata !== 32'h11111111) begin
      errors++; $display("FAIL tie_if_resp: got rv/dmrv/dmgnt=%b rd=%h want 100 11111111",
        {o_if_rvalid, o_dm_rvalid, o_dm_gnt}, o_if_rdata);
    end
    next_cyc(); i_mem_rvalid = 0; i_mem_rdata = 0; #1;
    checks++;
    if ({o_if_gnt, o_dm_gnt, o_mem_req, o_mem_we} !== 4'b0110 || o_mem_addr !== 32'h20) begin
      errors++; $display("FAIL tie_dm_grant: got %b addr=%h want 0110 addr=20",
        {o_if_gnt, o_dm_gnt, o_mem_req, o_mem_we}, o_mem_addr);
    end
    next_cyc(); i_dm_req = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h22222222; #1;
    checks++;
    if ({o_dm_rvalid, o_if_rvalid} !== 2'b10 || o_dm_rdata !== 32'h22222222 || o_if_rdata !== 32'h0) begin
      errors++; $display("FAIL tie_dm_resp: got rv=%b rd=%h ifrd=%h want 10 22222222 0",
        {o_dm_rvalid, o_if_rvalid}, o_dm_rdata, o_if_rdata);
    end
    next_cyc(); i_mem_rvalid = 0; i_mem_rdata = 0;
    i_if_req = 1; i_if_addr = 32'h30; i_dm_req = 1; i_dm_addr = 32'h34; #1;
    checks++;
    if ({o_if_gnt, o_dm_gnt} !== 2'b10 || o_mem_addr !== 32'h30) begin
      errors++; $display("FAIL tie_second: got gnt=%b addr=%h want 10 addr=30",
        {o_if_gnt, o_dm_gnt}, o_mem_addr);
    end
    next_cyc(); i_if_req = 0; i_dm_req = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h3;
    next_cyc(); i_mem_rvalid = 0; i_mem_rdata = 0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cyc();
      i_dm_req = 1; i_dm_we = 1; i_dm_addr = 32'h40; i_dm_wdata = 32'h55; #1;
      checks++;
      if ({o_dm_gnt, o_mem_req, o_mem_we} !== 3'b111 || o_mem_addr !== 32'h40 || o_mem_wdata !== 32'h55) begin
        errors++; $display("FAIL wr_b2b[%0d]: got gnt/req/we=%b addr=%h wd=%h want 111 40 55",
          k, {o_dm_gnt, o_mem_req, o_mem_we}, o_mem_addr, o_mem_wdata);
      end
    end
    next_cyc(); i_dm_req = 0; i_dm_we = 0; i_dm_addr = 0; i_dm_wdata = 0;
    i_if_req = 1; i_if_addr = 32'h44; #1;
    checks++;
    if ({o_if_gnt, o_mem_req} !== 2'b11 || o_mem_addr !== 32'h44) begin
      errors++; $display("FAIL wr_still_idle: got %b addr=%h want 11 addr=44",
        {o_if_gnt, o_mem_req}, o_mem_addr);
    end
    next_cyc(); i_if_req = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h5;
    next_cyc(); i_mem_rvalid = 0; i_mem_rdata = 0;
  endtask

  task automatic test_timeout();
    i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h80; #1;
    checks++;
    if (o_dm_gnt !== 1'b1) begin
      errors++; $display("FAIL to_grant: got %b want 1", o_dm_gnt);
    end
    next_cyc(); i_dm_req = 0;
    next_cyc();
    next_cyc(); #1;
    checks++;
    if ({o_dm_rvalid, o_err} !== 2'b00) begin
      errors++; $display("FAIL to_wait3: got %b want 00", {o_dm_rvalid, o_err});
    end
    next_cyc(); #1;
    checks++;
    if ({o_dm_rvalid, o_err, o_if_rvalid} !== 3'b110 || o_dm_rdata !== 32'h0) begin
      errors++; $display("FAIL to_fire: got rv/err/ifrv=%b rd=%h want 110 0",
        {o_dm_rvalid, o_err, o_if_rvalid}, o_dm_rdata);
    end
    next_cyc(); #1;
    checks++;
    if (o_err !== 1'b0) begin
      errors++; $display("FAIL to_err_pulse: got %b want 0", o_err);
    end
    next_cyc(); i_mem_rvalid = 1; i_mem_rdata = 32'hBAD; #1;
    checks++;
    if ({o_dm_rvalid, o_if_rvalid, o_err} !== 3'b000 || o_dm_rdata !== 32'h0) begin
      errors++; $display("FAIL to_stale: got %b rd=%h want 000 0",
        {o_dm_rvalid, o_if_rvalid, o_err}, o_dm_rdata);
    end
    next_cyc(); i_mem_rvalid = 0; i_mem_rdata = 0;
  endtask

  task automatic test_coincide();
    i_if_req = 1; i_if_addr = 32'h200;
    next_cyc(); i_if_req = 0;
    next_cyc();
    next_cyc();
    next_cyc(); i_mem_rvalid = 1; i_mem_rdata = 32'hCAFEF00D; #1;
    checks++;
    if ({o_if_rvalid, o_err} !== 2'b10 || o_if_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL coincide: got rv/err=%b rd=%h want 10 CAFEF00D",
        {o_if_rvalid, o_err}, o_if_rdata);
    end
    next_cyc(); i_mem_rvalid = 0; i_mem_rdata = 0;
  endtask

  task automatic test_reset_in_wait();
    i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h300;
    next_cyc(); i_dm_req = 0;
    #2; reset = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h1234; #1;
    checks++;
    if ({o_dm_rvalid, o_if_rvalid, o_err, o_mem_req} !== 4'b0000 || o_dm_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_wait: got %b rd=%h want 0000 0",
        {o_dm_rvalid, o_if_rvalid, o_err, o_mem_req}, o_dm_rdata);
    end
    next_cyc(); reset = 1; #1;
    checks++;
    if ({o_dm_rvalid, o_if_rvalid, o_err} !== 3'b000) begin
      errors++; $display("FAIL rst_after_stale: got %b want 000", {o_dm_rvalid, o_if_rvalid, o_err});
    end
    next_cyc(); i_mem_rvalid = 0; i_mem_rdata = 0; i_if_req = 1; i_if_addr = 32'h400; #1;
    checks++;
    if ({o_if_gnt, o_mem_req} !== 2'b11 || o_mem_addr !== 32'h400) begin
      errors++; $display("FAIL rst_regrant: got %b addr=%h want 11 addr=400",
        {o_if_gnt, o_mem_req}, o_mem_addr);
    end
    next_cyc(); i_if_req = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h600D; #1;
    checks++;
    if (o_if_rvalid !== 1'b1 || o_if_rdata !== 32'h600D) begin
      errors++; $display("FAIL rst_regrant_resp: got rv=%b rd=%h want 1 600D", o_if_rvalid, o_if_rdata);
    end
    next_cyc(); i_mem_rvalid = 0; i_mem_rdata = 0;
  endtask

  task automatic test_dropped_req();
    i_dm_req = 0; i_if_req = 0; #1;
    checks++;
    if ({o_if_gnt, o_dm_gnt, o_mem_req} !== 3'b000) begin
      errors++; $display("FAIL dropped: got %b want 000", {o_if_gnt, o_dm_gnt, o_mem_req});
    end
  endtask

  initial begin
    inputs_idle();
    test_reset();
    test_if_read();
    test_tie();
    test_back_to_back();
    test_timeout();
    test_coincide();
    test_reset_in_wait();
    test_dropped_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
